// File: rtl/zports_pkg.sv
// Shared definitions for the ZX port-window register block:
// register addresses, bit positions and reset-pulser state codes.
package zports_pkg;

  localparam logic [1:0] ADDR_NONE   = 2'd0;
  localparam logic [1:0] ADDR_CFG    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_INTENA = 2'd3;

  localparam int CFG_ENA    = 0;
  localparam int CFG_WIN_LO = 1;
  localparam int CFG_WIN_HI = 2;
  localparam int CFG_W5300  = 3;

  localparam int CTRL_SL811     = 0;
  localparam int CTRL_W5300     = 1;
  localparam int CTRL_SL811_INT = 4;
  localparam int CTRL_W5300_INT = 5;

  localparam int INT_SL811 = 0;
  localparam int INT_W5300 = 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

endpackage

// File: rtl/zports_rstgen.sv
// Per-chip hardware reset pulser: holds reset low, then
// keeps a busy flag through a recovery window.
module zports_rstgen
  import zports_pkg::*;
#(
  parameter int RST_LEN = 1000,
  parameter int REC_LEN = 4000,
  parameter int CNT_W   = 16
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic clr,
  input  logic start,
  output logic chip_rst_n,
  output logic busy
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_LEN - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;

  // State/count sequencing; starts are ignored unless idle.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ASSERT;
      count <= '0;
    end else if (clr) begin
      state <= ST_ASSERT;
      count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ASSERT;
            count <= '0;
          end
        end
        ST_ASSERT: begin
          if (count == RST_LAST) begin
            state <= ST_RECOVER;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (count == REC_LAST) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign chip_rst_n = (state != ST_ASSERT);
  assign busy       = (state != ST_IDLE);

endmodule

// File: rtl/zports.sv
// ZX port-window control block: write capture, config regs,
// chip reset sequencing and /INT aggregation.
module zports
  import zports_pkg::*;
#(
  parameter int RST_LEN = 1000,
  parameter int REC_LEN = 4000,
  parameter int CNT_W   = 16
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       zrst_n,
  input  logic       ports_wrena,
  input  logic       ports_wrstb_n,
  input  logic [1:0] ports_addr,
  input  logic [7:0] ports_wrdata,
  output logic [7:0] ports_rddata,
  output logic [1:0] rommap_win,
  output logic       rommap_ena,
  output logic       w5300_ports,
  output logic       sl811_rst_n,
  output logic       w5300_rst_n,
  input  logic       sl811_int,
  input  logic       w5300_int_n,
  output logic       zint_n
);

  logic       stb_s1, stb_s2, stb_h;
  logic       z_s1, z_s2;
  logic       sl_s1, sl_s2;
  logic       wi_s1, wi_s2;
  logic       wr_ev, zclr, wr_hit;
  logic       sl_start, w_start;
  logic       sl_busy, w_busy;
  logic [3:0] cfg;
  logic [1:0] intena;
  logic [1:0] int_req;
  logic       unused;

  // Synchronisers; idle levels at reset so nothing fires on release.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      stb_s1 <= 1'b1;
      stb_s2 <= 1'b1;
      stb_h  <= 1'b1;
      z_s1   <= 1'b1;
      z_s2   <= 1'b1;
      sl_s1  <= 1'b0;
      sl_s2  <= 1'b0;
      wi_s1  <= 1'b1;
      wi_s2  <= 1'b1;
    end else begin
      stb_s1 <= ports_wrstb_n;
      stb_s2 <= stb_s1;
      stb_h  <= stb_s2;
      z_s1   <= zrst_n;
      z_s2   <= z_s1;
      sl_s1  <= sl811_int;
      sl_s2  <= sl_s1;
      wi_s1  <= w5300_int_n;
      wi_s2  <= wi_s1;
    end
  end

  assign wr_ev  = stb_h & ~stb_s2;
  assign zclr   = ~z_s2;
  assign wr_hit = wr_ev & ports_wrena & ~zclr;

  assign sl_start = wr_hit & (ports_addr == ADDR_CTRL)
                  & ports_wrdata[CTRL_SL811];
  assign w_start  = wr_hit & (ports_addr == ADDR_CTRL)
                  & ports_wrdata[CTRL_W5300];

  // CFG and INTENA register writes, cleared by ZX reset.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg    <= '0;
      intena <= '0;
    end else if (zclr) begin
      cfg    <= '0;
      intena <= '0;
    end else if (wr_hit) begin
      if (ports_addr == ADDR_CFG)
        cfg <= ports_wrdata[3:0];
      if (ports_addr == ADDR_INTENA)
        intena <= ports_wrdata[1:0];
    end
  end

  zports_rstgen #(
    .RST_LEN(RST_LEN), .REC_LEN(REC_LEN), .CNT_W(CNT_W)
  ) u_sl811 (
    .fclk(fclk), .rst_n(rst_n), .clr(zclr), .start(sl_start),
    .chip_rst_n(sl811_rst_n), .busy(sl_busy)
  );

  zports_rstgen #(
    .RST_LEN(RST_LEN), .REC_LEN(REC_LEN), .CNT_W(CNT_W)
  ) u_w5300 (
    .fclk(fclk), .rst_n(rst_n), .clr(zclr), .start(w_start),
    .chip_rst_n(w5300_rst_n), .busy(w_busy)
  );

  // A chip held in reset cannot raise a meaningful interrupt.
  assign int_req[INT_SL811] = sl_s2 & sl811_rst_n;
  assign int_req[INT_W5300] = ~wi_s2 & w5300_rst_n;

  // Registered level-sensitive /INT.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n)
      zint_n <= 1'b1;
    else
      zint_n <= ~|(intena & int_req);
  end

  // Combinational read mux.
  always_comb begin
    ports_rddata = 8'hFF;
    unique case (ports_addr)
      ADDR_NONE: ports_rddata = 8'hFF;
      ADDR_CFG:  ports_rddata = {4'b0, cfg};
      ADDR_CTRL: begin
        ports_rddata = 8'h00;
        ports_rddata[CTRL_SL811]     = sl_busy;
        ports_rddata[CTRL_W5300]     = w_busy;
        ports_rddata[CTRL_SL811_INT] = sl_s2;
        ports_rddata[CTRL_W5300_INT] = ~wi_s2;
      end
      ADDR_INTENA: ports_rddata = {6'b0, intena};
      default:     ports_rddata = 8'hFF;
    endcase
  end

  assign rommap_ena  = cfg[CFG_ENA];
  assign rommap_win  = cfg[CFG_WIN_HI:CFG_WIN_LO];
  assign w5300_ports = cfg[CFG_W5300];

  assign unused = ^ports_wrdata[7:4];

endmodule
